// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } md_state_t;

   // Quotient returned on divide-by-zero; sliced down to the operand width.
   localparam logic [63:0] DIV0_QUOT = {64{1'b1}};

   function automatic logic md_is_signed(input md_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic md_is_div(input md_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per step.
// After WIDTH steps following a load, quot_o/rem_o hold the unsigned result.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // Trial subtraction of the divisor from the shifted partial remainder.
   always_comb begin
      rem_sh = {rem_q, quot_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      rem_d  = rem_q;
      quot_d = quot_q;
      if (load_i) begin
         rem_d  = '0;
         quot_d = dividend_i;
      end else if (step_i) begin
         if (!diff[WIDTH]) begin
            rem_d  = diff[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d  = rem_sh[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Partial remainder, quotient/dividend shift register and held divisor.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_q  <= '0;
         quot_q <= '0;
         dvs_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         if (load_i) dvs_q <= divisor_i;
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//
//  state | meaning
//  IDLE  | no op in flight; MTHI/MTLO accepted, start accepted
//  MUL   | latency countdown for MULT/MULTU, product written at count 0
//  DIV   | one restoring step per cycle on operand magnitudes
//  FIX   | sign correction / divide-by-zero result, HI/LO written
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_hilo_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   md_state_t        state_q, state_d;
   md_op_t           op_in, op_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             accept, cnt_zero;
   logic             div_load, div_step, wr_mul, wr_fix;
   logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
   logic             sgn, q_neg, r_neg;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;

   assign op_in    = md_op_t'(op_i);
   assign accept   = start_i && (state_q == IDLE) && !flush_i;
   assign cnt_zero = (cnt_q == '0);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; flush overrides completion and a same-cycle start.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               if (!md_is_div(op_in)) state_d = MUL;
               else if (b_i == '0)    state_d = FIX;
               else                   state_d = DIV;
            end
            MUL:  if (cnt_zero) state_d = IDLE;
            DIV:  if (cnt_zero) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Per-state outputs and datapath strobes.
   always_comb begin
      busy_o   = (state_q != IDLE);
      div_load = accept && md_is_div(op_in);
      div_step = (state_q == DIV);
      wr_mul   = (state_q == MUL) && cnt_zero && !flush_i;
      wr_fix   = (state_q == FIX) && !flush_i;
   end

   assign stall_o = busy_o && (start_i || mthi_i || mtlo_i || rd_hilo_i);

   // Latency down-counter.
   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)
         cnt_d = '0;
      else if (accept)
         cnt_d = md_is_div(op_in) ? CW'(WIDTH - 1) : CW'(MUL_CYCLES - 1);
      else if ((state_q == MUL || state_q == DIV) && !cnt_zero)
         cnt_d = cnt_q - 1'b1;
   end

   // Counter and operand latches captured on accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         op_q  <= OP_MULT;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            op_q <= op_in;
            a_q  <= a_i;
            b_q  <= b_i;
         end
      end
   end

   // Divider runs on magnitudes; signs are restored in FIX.
   assign a_mag = (md_is_signed(op_in) && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_mag = (md_is_signed(op_in) && b_i[WIDTH-1]) ? -b_i : b_i;

   div_iter #(.WIDTH(WIDTH)) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .quot_o     (quot),
      .rem_o      (rem)
   );

   assign sgn   = md_is_signed(op_q);
   assign q_neg = sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
   assign r_neg = sgn && a_q[WIDTH-1];
   assign a_ext = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
   assign b_ext = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
   assign prod  = a_ext * b_ext;

   // HI/LO next value: op results while busy, MTHI/MTLO only while idle.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wr_mul) begin
         {hi_d, lo_d} = prod;
      end else if (wr_fix) begin
         if (b_q == '0) begin
            hi_d = a_q;
            lo_d = DIV0_QUOT[WIDTH-1:0];
         end else begin
            hi_d = r_neg ? -rem  : rem;
            lo_d = q_neg ? -quot : quot;
         end
      end else if (!busy_o) begin
         if (mthi_i) hi_d = wdata_i;
         if (mtlo_i) lo_d = wdata_i;
      end
   end

   // Architectural HI/LO registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vectors, random ops against
// an arithmetic reference model, and hand-written handshake sequences.
module tb_muldiv_ctrl;

   localparam int W  = 32;
   localparam int MC = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, flush, mthi, mtlo, rd_hilo;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wdata;
   logic          busy, stall;
   logic [W-1:0]  hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .op_i      (op),
      .a_i       (a),
      .b_i       (b),
      .flush_i   (flush),
      .mthi_i    (mthi),
      .mtlo_i    (mtlo),
      .wdata_i   (wdata),
      .rd_hilo_i (rd_hilo),
      .busy_o    (busy),
      .stall_o   (stall),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      int           cyc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic [1:0] o, input logic [W-1:0] va, vb, vh, vl,
                                   input int c);
      vec_t v;
      v.op = o; v.a = va; v.b = vb; v.hi = vh; v.lo = vl; v.cyc = c;
      vecs.push_back(v);
   endfunction

   // Reference: plain 64-bit arithmetic from the architectural definition.
   function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] va, vb,
                                     output logic [W-1:0] rh, rl, output int c);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      logic [63:0]     r64;
      sa = longint'($signed(va));
      sb = longint'($signed(vb));
      ua = {32'b0, va};
      ub = {32'b0, vb};
      case (o)
         2'd0: begin r64 = sa * sb; {rh, rl} = r64; c = MC; end
         2'd1: begin up = ua * ub; {rh, rl} = up; c = MC; end
         2'd2: begin
            if (vb == '0) begin rh = va; rl = '1; c = 1; end
            else begin
               sq = sa / sb; sr = sa % sb;
               r64 = sq; rl = r64[31:0];
               r64 = sr; rh = r64[31:0];
               c = W + 1;
            end
         end
         default: begin
            if (vb == '0) begin rh = va; rl = '1; c = 1; end
            else begin
               up = ua / ub; rl = up[31:0];
               up = ua % ub; rh = up[31:0];
               c = W + 1;
            end
         end
      endcase
   endfunction

   // Issue one op, count busy cycles until it drops (bounded), return HI/LO.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, vb,
                         output logic [W-1:0] rh, rl, output int c);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      c = n; rh = hi; rl = lo;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [W-1:0] rh, rl, eh, el, sh, sl;
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      int           c, ec, n, bad;

      rst_n = 1'b0; start = 0; flush = 0; mthi = 0; mtlo = 0; rd_hilo = 1'b1;
      op = 2'd0; a = '0; b = '0; wdata = '0;
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_stall", stall, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; rd_hilo = 1'b0;

      add_vec(2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MC);
      add_vec(2'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC);
      add_vec(2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, W + 1);
      add_vec(2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1);
      add_vec(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, W + 1);
      add_vec(2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, W + 1);
      add_vec(2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1);
      add_vec(2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC);
      add_vec(2'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, W + 1);
      add_vec(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MC);
      add_vec(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC);
      add_vec(2'd3, 32'd10,       32'd3,        32'h00000001, 32'h00000003, W + 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, c);
         chk($sformatf("vec%0d_hi", i), rh, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), rl, vecs[i].lo);
         chk($sformatf("vec%0d_cycles", i), c, vecs[i].cyc);
      end

      for (int i = 0; i < 60; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = '1;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         ref_model(ro, ra, rb, eh, el, ec);
         run_op(ro, ra, rb, rh, rl, c);
         chk($sformatf("rand%0d_hi op%0d %0h %0h", i, ro, ra, rb), rh, eh);
         chk($sformatf("rand%0d_lo op%0d %0h %0h", i, ro, ra, rb), rl, el);
         chk($sformatf("rand%0d_cycles", i), c, ec);
      end

      // MTHI alone while idle, then MTHI+MTLO together.
      @(negedge clk);
      sl = lo; mthi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_lo_kept", lo, sl);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      chk("mthi_both_hi", hi, 32'hCAFE);
      chk("mtlo_both_lo", lo, 32'hCAFE);

      // MFHI/MFLO held by stall during DIVU 10/3 from busy cycle 5.
      @(negedge clk);
      start = 1'b1; op = 2'd3; a = 32'd10; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rd_hilo = 1'b1;
      #1;
      chk("rdhilo_stall_asserted", stall, 1);
      bad = 0; n = 0;
      while (busy && n < 100) begin
         if (!stall) bad++;
         @(negedge clk);
         n++;
      end
      chk("rdhilo_stall_held", bad, 0);
      chk("rdhilo_remaining_busy", n, W + 1 - 4);
      chk("rdhilo_stall_released", stall, 0);
      rd_hilo = 1'b0;
      chk("rdhilo_lo", lo, 3);
      chk("rdhilo_hi", hi, 1);

      // Flush at DIV busy cycle 10: aborted, HI/LO untouched, no late write.
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b0; wdata = 32'hAAAA;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5555;
      @(negedge clk);
      mtlo = 1'b0;
      start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_hi", hi, 32'hAAAA);
      chk("flush_lo", lo, 32'h5555);
      repeat (40) @(negedge clk);
      chk("flush_no_late_hi", hi, 32'hAAAA);
      chk("flush_no_late_lo", lo, 32'h5555);

      // Flush on the completing MUL cycle beats the product write.
      start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (MC - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_last_busy", busy, 0);
      chk("flush_last_lo", lo, 32'h5555);

      // Flush beats a same-cycle start.
      start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", busy, 0);

      // Start while busy: stalled and not accepted.
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'd3; a = 32'd1; b = 32'd0;
      #1;
      chk("busy_start_stall", stall, 1);
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      chk("busy_start_cycles", n + 2, MC);
      chk("busy_start_lo", lo, 30);
      chk("busy_start_hi", hi, 0);
      @(negedge clk);
      chk("busy_start_not_queued", busy, 0);

      // MTHI while busy is held off.
      mthi = 1'b1; wdata = 32'd77;
      @(negedge clk);
      mthi = 1'b0;
      start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      mthi = 1'b1; wdata = 32'hDEAD;
      #1;
      chk("mthi_busy_stall", stall, 1);
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi_busy_hi_kept", hi, 77);
      wait_idle(n);
      chk("mthi_busy_final_hi", hi, 0);
      chk("mthi_busy_final_lo", lo, 9);

      // Same-cycle start and MTHI while idle.
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3; mthi = 1'b1; wdata = 32'hBEEF;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      chk("start_mthi_hi", hi, 32'hBEEF);
      chk("start_mthi_busy", busy, 1);
      wait_idle(n);
      chk("start_mthi_final_hi", hi, 0);
      chk("start_mthi_final_lo", lo, 6);

      // Async reset mid-MUL.
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      start = 1'b1; op = 2'd0; a = 32'd4; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_hi", hi, 0);
      chk("areset_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("areset_stays_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
